// File: rtl/riscv_bus_pkg.sv
// rtl/riscv_bus_pkg.sv - shared widths and wait-controller state type for the data RAM bus
package riscv_bus_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int WAIT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wait_state_e;

endpackage

// File: rtl/dualport_bus_if.sv
// rtl/dualport_bus_if.sv - independent read and write request/grant channels
interface dualport_bus;
    import riscv_bus_pkg::*;

    logic              rd_req;
    logic [WORD_W-1:0] rd_addr;
    logic [BE_W-1:0]   rd_be;
    logic              rd_gnt;
    logic [WORD_W-1:0] rd_data;

    logic              wr_req;
    logic [WORD_W-1:0] wr_addr;
    logic [BE_W-1:0]   wr_be;
    logic [WORD_W-1:0] wr_data;
    logic              wr_gnt;

    modport master (
        output rd_req, rd_addr, rd_be,
        input  rd_gnt, rd_data,
        output wr_req, wr_addr, wr_be, wr_data,
        input  wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, rd_be,
        output rd_gnt, rd_data,
        input  wr_req, wr_addr, wr_be, wr_data,
        output wr_gnt
    );

endinterface

// File: rtl/riscv_bus_wait_ctrl.sv
// rtl/riscv_bus_wait_ctrl.sv - grants a held request after N wait cycles
module riscv_bus_wait_ctrl
    import riscv_bus_pkg::*;
#(
    parameter int N = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic gnt
);

    localparam logic [WAIT_W-1:0] RELOAD = (N > 0) ? WAIT_W'(N - 1) : '0;

    wait_state_e       state, state_nx;
    logic [WAIT_W-1:0] cnt, cnt_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gnt      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (N == 0) begin
                        gnt = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = RELOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    gnt      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        // Reset is asynchronous, so the grant must drop with it, not at the next edge.
        if (!rst_n) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: rtl/riscv_data_ram.sv
// rtl/riscv_data_ram.sv - word-organised data RAM with independent wait-stated read and write ports
module riscv_data_ram
    import riscv_bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_WAIT    = 0,
    parameter int WR_WAIT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    dualport_bus.slave  mem_slave
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  rd_in_range;
    logic                  wr_in_range;
    logic [WORD_W-1:0]     rd_data_q;
    logic                  unused_bits;

    riscv_bus_wait_ctrl #(.N(RD_WAIT)) u_rd_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (mem_slave.rd_req),
        .gnt   (rd_gnt)
    );

    riscv_bus_wait_ctrl #(.N(WR_WAIT)) u_wr_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (mem_slave.wr_req),
        .gnt   (wr_gnt)
    );

    assign mem_slave.rd_gnt  = rd_gnt;
    assign mem_slave.wr_gnt  = wr_gnt;
    assign mem_slave.rd_data = rd_data_q;

    assign rd_idx      = mem_slave.rd_addr[DEPTH_LOG2+1:2];
    assign wr_idx      = mem_slave.wr_addr[DEPTH_LOG2+1:2];
    assign rd_in_range = ~|mem_slave.rd_addr[WORD_W-1:DEPTH_LOG2+2];
    assign wr_in_range = ~|mem_slave.wr_addr[WORD_W-1:DEPTH_LOG2+2];

    // Reads always return the full word; byte enables and low address bits are don't-care.
    assign unused_bits = ^{mem_slave.rd_be, mem_slave.rd_addr[1:0], mem_slave.wr_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_gnt) begin
            rd_data_q <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

    // Array is deliberately not reset; the old word is read above before this update lands.
    always_ff @(posedge clk) begin
        if (wr_gnt && wr_in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_slave.wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= mem_slave.wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_data_ram.sv
// tb/tb_riscv_data_ram.sv - randomized and directed checks of riscv_data_ram against a word-map model
module tb_riscv_data_ram;

    localparam int RDW1 = 3;
    localparam int WRW1 = 4;
    localparam int MAXC = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd_req_t  [2];
    logic [31:0] rd_addr_t [2];
    logic [3:0]  rd_be_t   [2];
    logic        rd_gnt_t  [2];
    logic [31:0] rd_data_t [2];
    logic        wr_req_t  [2];
    logic [31:0] wr_addr_t [2];
    logic [3:0]  wr_be_t   [2];
    logic [31:0] wr_data_t [2];
    logic        wr_gnt_t  [2];

    int rd_n [2];
    int wr_n [2];
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] model [int];

    dualport_bus bus0 ();
    dualport_bus bus1 ();

    assign bus0.rd_req = rd_req_t[0];  assign bus1.rd_req = rd_req_t[1];
    assign bus0.rd_addr = rd_addr_t[0]; assign bus1.rd_addr = rd_addr_t[1];
    assign bus0.rd_be = rd_be_t[0];    assign bus1.rd_be = rd_be_t[1];
    assign bus0.wr_req = wr_req_t[0];  assign bus1.wr_req = wr_req_t[1];
    assign bus0.wr_addr = wr_addr_t[0]; assign bus1.wr_addr = wr_addr_t[1];
    assign bus0.wr_be = wr_be_t[0];    assign bus1.wr_be = wr_be_t[1];
    assign bus0.wr_data = wr_data_t[0]; assign bus1.wr_data = wr_data_t[1];
    assign rd_gnt_t[0] = bus0.rd_gnt;  assign rd_gnt_t[1] = bus1.rd_gnt;
    assign rd_data_t[0] = bus0.rd_data; assign rd_data_t[1] = bus1.rd_data;
    assign wr_gnt_t[0] = bus0.wr_gnt;  assign wr_gnt_t[1] = bus1.wr_gnt;

    riscv_data_ram #(.DEPTH_LOG2(12), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_slave(bus0)
    );
    riscv_data_ram #(.DEPTH_LOG2(12), .RD_WAIT(RDW1), .WR_WAIT(WRW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_slave(bus1)
    );

    function automatic bit in_range(input logic [31:0] a);
        return (a >> 14) == 0;
    endfunction

    function automatic int key(input int i, input logic [31:0] a);
        return i * 65536 + int'((a >> 2) & 32'h0000_0FFF);
    endfunction

    function automatic void model_write(input int i, input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        if (!in_range(a)) return;
        w = model.exists(key(i, a)) ? model[key(i, a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        model[key(i, a)] = w;
    endfunction

    task automatic do_read(input int i, input logic [31:0] a, output int cyc, output logic [31:0] d);
        bit got = 0;
        rd_addr_t[i] = a;
        rd_be_t[i]   = 4'($urandom_range(0, 15));
        rd_req_t[i]  = 1'b1;
        cyc = 0;
        while (!got && cyc < MAXC) begin
            @(negedge clk);
            cyc++;
            if (rd_gnt_t[i]) got = 1;
        end
        @(posedge clk); #1;
        rd_req_t[i] = 1'b0;
        d = rd_data_t[i];
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, output int cyc);
        bit got = 0;
        wr_addr_t[i] = a;
        wr_be_t[i]   = be;
        wr_data_t[i] = d;
        wr_req_t[i]  = 1'b1;
        cyc = 0;
        while (!got && cyc < MAXC) begin
            @(negedge clk);
            cyc++;
            if (wr_gnt_t[i]) got = 1;
        end
        @(posedge clk); #1;
        wr_req_t[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_req_t[0] = 1'b1; rd_req_t[1] = 1'b1;
        wr_req_t[0] = 1'b1; wr_req_t[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (rd_gnt_t[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_gnt[%0d] got %b want 0", i, rd_gnt_t[i]); end
            n_cmp++; if (wr_gnt_t[i] !== 1'b0) begin n_fail++; $display("FAIL reset_wr_gnt[%0d] got %b want 0", i, wr_gnt_t[i]); end
            n_cmp++; if (rd_data_t[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data[%0d] got %h want 0", i, rd_data_t[i]); end
        end
        for (int i = 0; i < 2; i++) begin rd_req_t[i] = 1'b0; wr_req_t[i] = 1'b0; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_rw();
        int cyc; logic [31:0] d;
        for (int i = 0; i < 2; i++) begin
            do_write(i, 32'h10, 4'hF, 32'hDEADBEEF, cyc);
            model_write(i, 32'h10, 4'hF, 32'hDEADBEEF);
            n_cmp++; if (cyc !== wr_n[i] + 1) begin n_fail++; $display("FAIL basic_wr_lat[%0d] got %0d want %0d", i, cyc, wr_n[i] + 1); end
            do_read(i, 32'h10, cyc, d);
            n_cmp++; if (cyc !== rd_n[i] + 1) begin n_fail++; $display("FAIL basic_rd_lat[%0d] got %0d want %0d", i, cyc, rd_n[i] + 1); end
            n_cmp++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data[%0d] got %h want deadbeef", i, d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        rd_addr_t[1] = 32'h10; rd_be_t[1] = 4'h0; rd_req_t[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_gnt_t[1] !== 1'(((k + 1) % (RDW1 + 1)) == 0)) begin
                n_fail++; $display("FAIL b2b_rd_gnt cycle %0d got %b want %b", k, rd_gnt_t[1], ((k + 1) % (RDW1 + 1)) == 0);
            end
        end
        @(posedge clk); #1;
        rd_req_t[1] = 1'b0;
        n_cmp++; if (rd_data_t[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd_data got %h want deadbeef", rd_data_t[1]); end
        wd = $urandom;
        wr_addr_t[1] = 32'h14; wr_be_t[1] = 4'hF; wr_data_t[1] = wd; wr_req_t[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (wr_gnt_t[1] !== 1'(((k + 1) % (WRW1 + 1)) == 0)) begin
                n_fail++; $display("FAIL b2b_wr_gnt cycle %0d got %b want %b", k, wr_gnt_t[1], ((k + 1) % (WRW1 + 1)) == 0);
            end
        end
        @(posedge clk); #1;
        wr_req_t[1] = 1'b0;
        model_write(1, 32'h14, 4'hF, wd);
    endtask

    task automatic test_byte_write();
        int cyc; logic [31:0] d;
        for (int i = 0; i < 2; i++) begin
            do_write(i, 32'h30, 4'hF, 32'h11223344, cyc);
            do_write(i, 32'h30, 4'b0010, 32'h0000AB00, cyc);
            do_read(i, 32'h30, cyc, d);
            n_cmp++; if (d !== 32'h1122AB44) begin n_fail++; $display("FAIL byte_lane[%0d] got %h want 1122ab44", i, d); end
            do_write(i, 32'h30, 4'h0, 32'hFFFFFFFF, cyc);
            n_cmp++; if (cyc !== wr_n[i] + 1) begin n_fail++; $display("FAIL be0_lat[%0d] got %0d want %0d", i, cyc, wr_n[i] + 1); end
            do_read(i, 32'h30, cyc, d);
            n_cmp++; if (d !== 32'h1122AB44) begin n_fail++; $display("FAIL be0_nochange[%0d] got %h want 1122ab44", i, d); end
            model_write(i, 32'h30, 4'hF, 32'h1122AB44);
        end
    endtask

    task automatic test_read_before_write();
        int cyc; logic [31:0] d;
        do_write(0, 32'h20, 4'hF, 32'h1, cyc);
        rd_addr_t[0] = 32'h20; rd_be_t[0] = 4'hF; rd_req_t[0] = 1'b1;
        wr_addr_t[0] = 32'h20; wr_be_t[0] = 4'hF; wr_data_t[0] = 32'h2; wr_req_t[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rd_gnt_t[0], wr_gnt_t[0]} !== 2'b11) begin n_fail++; $display("FAIL rbw_gnts got %b want 11", {rd_gnt_t[0], wr_gnt_t[0]}); end
        @(posedge clk); #1;
        rd_req_t[0] = 1'b0; wr_req_t[0] = 1'b0;
        n_cmp++; if (rd_data_t[0] !== 32'h1) begin n_fail++; $display("FAIL rbw_old got %h want 00000001", rd_data_t[0]); end
        do_read(0, 32'h20, cyc, d);
        n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL rbw_new got %h want 00000002", d); end
        model_write(0, 32'h20, 4'hF, 32'h2);
    endtask

    task automatic test_abort();
        int cyc; logic [31:0] d;
        do_write(1, 32'h40, 4'hF, 32'hA5A50001, cyc);
        wr_addr_t[1] = 32'h40; wr_be_t[1] = 4'hF; wr_data_t[1] = 32'h0; wr_req_t[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (wr_gnt_t[1] !== 1'b0) begin n_fail++; $display("FAIL abort_hold_gnt cycle %0d got %b want 0", k, wr_gnt_t[1]); end
        end
        @(posedge clk); #1;
        wr_req_t[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (wr_gnt_t[1] !== 1'b0) begin n_fail++; $display("FAIL abort_after_gnt cycle %0d got %b want 0", k, wr_gnt_t[1]); end
        end
        @(posedge clk); #1;
        do_read(1, 32'h40, cyc, d);
        n_cmp++; if (d !== 32'hA5A50001) begin n_fail++; $display("FAIL abort_mem got %h want a5a50001", d); end
        do_write(1, 32'h40, 4'hF, 32'hA5A50002, cyc);
        n_cmp++; if (cyc !== WRW1 + 1) begin n_fail++; $display("FAIL abort_restart_lat got %0d want %0d", cyc, WRW1 + 1); end
        model_write(1, 32'h40, 4'hF, 32'hA5A50002);
    endtask

    task automatic test_reset_mid_wait();
        int cyc; logic [31:0] d;
        bit got = 0;
        do_write(1, 32'h44, 4'hF, 32'h0BADF00D, cyc);
        model_write(1, 32'h44, 4'hF, 32'h0BADF00D);
        do_read(0, 32'h10, cyc, d);
        rd_addr_t[1] = 32'h10; rd_be_t[1] = 4'hF; rd_req_t[1] = 1'b1;
        wr_addr_t[1] = 32'h44; wr_be_t[1] = 4'hF; wr_data_t[1] = 32'h12345678; wr_req_t[1] = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rd_gnt_t[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_gnt got %b want 0", rd_gnt_t[1]); end
        n_cmp++; if (wr_gnt_t[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_gnt got %b want 0", wr_gnt_t[1]); end
        n_cmp++; if (rd_data_t[1] !== 32'h0) begin n_fail++; $display("FAIL midrst_rd_data1 got %h want 0", rd_data_t[1]); end
        n_cmp++; if (rd_data_t[0] !== 32'h0) begin n_fail++; $display("FAIL midrst_rd_data0 got %h want 0", rd_data_t[0]); end
        wr_req_t[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        while (!got && cyc < MAXC) begin
            @(negedge clk);
            cyc++;
            if (rd_gnt_t[1]) got = 1;
        end
        @(posedge clk); #1;
        rd_req_t[1] = 1'b0;
        n_cmp++; if (cyc !== RDW1 + 1) begin n_fail++; $display("FAIL postrst_lat got %0d want %0d", cyc, RDW1 + 1); end
        n_cmp++; if (rd_data_t[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL postrst_mem_kept got %h want deadbeef", rd_data_t[1]); end
        do_read(1, 32'h44, cyc, d);
        n_cmp++; if (d !== 32'h0BADF00D) begin n_fail++; $display("FAIL midrst_no_write got %h want 0badf00d", d); end
    endtask

    task automatic test_out_of_range();
        int cyc; logic [31:0] d;
        do_write(0, 32'h0, 4'hF, 32'h600DCAFE, cyc);
        model_write(0, 32'h0, 4'hF, 32'h600DCAFE);
        do_read(0, 32'h0, cyc, d);
        do_read(0, 32'hFFFF0000, cyc, d);
        n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL oor_rd_lat got %0d want 1", cyc); end
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data got %h want 0", d); end
        do_write(0, 32'hFFFF0000, 4'hF, 32'h55AA55AA, cyc);
        n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL oor_wr_lat got %0d want 1", cyc); end
        do_read(0, 32'h0, cyc, d);
        n_cmp++; if (d !== 32'h600DCAFE) begin n_fail++; $display("FAIL oor_wr_dropped got %h want 600dcafe", d); end
        do_read(1, 32'hFFFF0000, cyc, d);
        n_cmp++; if (cyc !== RDW1 + 1 || d !== 32'h0) begin n_fail++; $display("FAIL oor_rd1 got lat %0d data %h want lat %0d data 0", cyc, d, RDW1 + 1); end
    endtask

    task automatic test_random();
        int cyc; logic [31:0] d, a, wd, exp_d; logic [3:0] be; int i;
        for (int ii = 0; ii < 2; ii++) begin
            for (int k = 0; k < 16; k++) begin
                wd = $urandom;
                do_write(ii, 32'h400 + 32'(4 * k), 4'hF, wd, cyc);
                model_write(ii, 32'h400 + 32'(4 * k), 4'hF, wd);
            end
        end
        for (int n = 0; n < 80; n++) begin
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h0001_0000 | (32'($urandom_range(0, 4095)) << 2);
            else a = 32'h400 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                do_read(i, a, cyc, d);
                exp_d = in_range(a) ? model[key(i, a)] : 32'h0;
                n_cmp++; if (cyc !== rd_n[i] + 1) begin n_fail++; $display("FAIL rnd_rd_lat op %0d got %0d want %0d", n, cyc, rd_n[i] + 1); end
                n_cmp++; if (d !== exp_d) begin n_fail++; $display("FAIL rnd_rd_data op %0d inst %0d addr %h got %h want %h", n, i, a, d, exp_d); end
            end else begin
                wd = $urandom;
                be = 4'($urandom_range(0, 15));
                do_write(i, a, be, wd, cyc);
                model_write(i, a, be, wd);
                n_cmp++; if (cyc !== wr_n[i] + 1) begin n_fail++; $display("FAIL rnd_wr_lat op %0d got %0d want %0d", n, cyc, wr_n[i] + 1); end
            end
        end
    endtask

    initial begin
        rd_n[0] = 0; rd_n[1] = RDW1;
        wr_n[0] = 0; wr_n[1] = WRW1;
        for (int i = 0; i < 2; i++) begin
            rd_req_t[i] = 1'b0; rd_addr_t[i] = '0; rd_be_t[i] = '0;
            wr_req_t[i] = 1'b0; wr_addr_t[i] = '0; wr_be_t[i] = '0; wr_data_t[i] = '0;
        end
        test_reset();
        test_basic_rw();
        test_back_to_back();
        test_byte_write();
        test_read_before_write();
        test_abort();
        test_reset_mid_wait();
        test_out_of_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
